// File: rtl/sca_pkg.sv
// rtl/sca_pkg.sv - shared FSM state type and width/block-count helpers for the synaptic current accumulator
package sca_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } sca_state_t;

    // Accumulator width: worst case M weights of W bits cannot overflow.
    function automatic int sca_acc_width(input int w, input int m);
        return w + $clog2(m) + 1;
    endfunction

    // Width of one block's partial sum.
    function automatic int sca_lane_sum_width(input int w, input int lanes);
        return w + $clog2(lanes) + 1;
    endfunction

    // Number of LANES-wide blocks needed to cover M synapses.
    function automatic int sca_num_blocks(input int m, input int lanes);
        return (m + lanes - 1) / lanes;
    endfunction

    // Counter width able to index n items, at least one bit.
    function automatic int sca_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sca_lane_sum.sv
// rtl/sca_lane_sum.sv - combinational masked signed sum of one block of synapse weights
module sca_lane_sum
    import sca_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = 8,
    localparam int SUM_W = sca_lane_sum_width(W, LANES)
) (
    input  logic [LANES-1:0]        spikes,
    input  logic [LANES*W-1:0]      weights,
    output logic signed [SUM_W-1:0] sum
);

    // Add each weight whose spike bit is set, sign-extended to the sum width.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (spikes[i]) begin
                sum = sum + SUM_W'($signed(weights[i*W +: W]));
            end
        end
    end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// rtl/synaptic_current_accumulator.sv - multi-cycle spike-gated weight accumulator with saturated output; optional bias via SCA_BIAS_EN
module synaptic_current_accumulator
    import sca_pkg::*;
#(
    parameter int M     = 24,
    parameter int W     = 8,
    parameter int OUT_W = 8,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [M-1:0]            input_spikes,
    input  logic [M*W-1:0]          weights,
`ifdef SCA_BIAS_EN
    input  logic signed [W-1:0]     bias,
`endif
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] input_current,
    output logic                    saturated
);

    localparam int ACC_W = sca_acc_width(W, M);
    localparam int SUM_W = sca_lane_sum_width(W, LANES);
    localparam int NB    = sca_num_blocks(M, LANES);
    localparam int PAD_W = NB * LANES;
    localparam int BLK_W = sca_idx_width(NB);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [BLK_W-1:0]        LAST_BLK = BLK_W'(NB - 1);

    sca_state_t                 state;
    sca_state_t                 state_nxt;
    logic [M-1:0]               spk_q;
    logic [M*W-1:0]             wts_q;
    logic [PAD_W-1:0]           spk_pad;
    logic [PAD_W*W-1:0]         wts_pad;
    logic [LANES-1:0]           blk_spk;
    logic [LANES*W-1:0]         blk_wts;
    logic signed [SUM_W-1:0]    blk_sum;
    logic signed [ACC_W-1:0]    acc;
    logic [BLK_W-1:0]           blk;
    logic                       last_blk;
    logic signed [OUT_W-1:0]    sat_val;
    logic                       sat_flag;

    assign busy     = (state != IDLE);
    assign last_blk = (blk == LAST_BLK);

    // Zero-pad the captured operands so the final block's unused lanes read as silent synapses.
    always_comb begin
        spk_pad            = '0;
        wts_pad            = '0;
        spk_pad[M-1:0]     = spk_q;
        wts_pad[M*W-1:0]   = wts_q;
        blk_spk            = spk_pad[int'(blk)*LANES +: LANES];
        blk_wts            = wts_pad[int'(blk)*LANES*W +: LANES*W];
    end

    sca_lane_sum #(
        .LANES (LANES),
        .W     (W)
    ) u_lane_sum (
        .spikes  (blk_spk),
        .weights (blk_wts),
        .sum     (blk_sum)
    );

    // Clamp the full-width accumulator into the signed output range.
    always_comb begin
        sat_flag = 1'b0;
        sat_val  = acc[OUT_W-1:0];
        if (acc > SAT_MAX) begin
            sat_flag = 1'b1;
            sat_val  = SAT_MAX[OUT_W-1:0];
        end else if (acc < SAT_MIN) begin
            sat_flag = 1'b1;
            sat_val  = SAT_MIN[OUT_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start is only honoured in IDLE; FINISH always returns to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)    state_nxt = ACCUM;
            ACCUM:   if (last_blk) state_nxt = FINISH;
            FINISH:                state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand capture, block accumulation and result publication.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spk_q         <= '0;
            wts_q         <= '0;
            acc           <= '0;
            blk           <= '0;
            done          <= 1'b0;
            input_current <= '0;
            saturated     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        spk_q <= input_spikes;
                        wts_q <= weights;
                        blk   <= '0;
`ifdef SCA_BIAS_EN
                        acc   <= ACC_W'(bias);
`else
                        acc   <= '0;
`endif
                    end
                end
                ACCUM: begin
                    acc <= acc + ACC_W'(blk_sum);
                    if (!last_blk) begin
                        blk <= blk + 1'b1;
                    end
                end
                FINISH: begin
                    done          <= 1'b1;
                    input_current <= sat_val;
                    saturated     <= sat_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/synaptic_current_accumulator.md
SYNAPTIC_CURRENT_ACCUMULATOR -- requirements
Module: synaptic_current_accumulator

Interface
REQ-001 SHALL have parameter M, default 24, number of input synapses.
REQ-002 SHALL have parameter W, default 8, signed two's-complement weight width.
REQ-003 SHALL have parameter OUT_W, default 8, signed output current width.
REQ-004 SHALL have parameter LANES, default 4, synapses summed per cycle (1..M).
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port start, input, 1, request a new accumulation.
REQ-008 SHALL have port input_spikes, input, M, spike vector; bit i gates weight i.
REQ-009 SHALL have port weights, input, M*W, weight i at bits [i*W +: W], signed.
REQ-010 SHALL have port busy, output, 1, high while accumulating.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking a new result.
REQ-012 SHALL have port input_current, output, OUT_W, saturated signed result, held until the next done.
REQ-013 SHALL have port saturated, output, 1, high when the held result was clamped.

Function
REQ-014 SHALL run a FSM with states IDLE, ACCUM, FINISH.
REQ-015 In IDLE, start=1 SHALL register input_spikes and weights, clear the accumulator and block index, and enter ACCUM; later input changes SHALL NOT affect the result.
REQ-016 In ACCUM, each cycle SHALL add the sign-extended weights of spiking synapses in block k (indices k*LANES..k*LANES+LANES-1) to the accumulator; indices >= M contribute 0.
REQ-017 After block NB-1, NB = ceil(M/LANES), the FSM SHALL enter FINISH.
REQ-018 FINISH SHALL last one cycle, load input_current and saturated, pulse done, and return to IDLE.
REQ-019 done SHALL assert exactly NB+1 cycles after the clock edge accepting start; with defaults, 7.
REQ-020 busy SHALL be high in ACCUM and FINISH and low in IDLE.
REQ-021 The accumulator width SHALL be W + clog2(M) + 1 bits, so no internal overflow.
REQ-022 Results above 2^(OUT_W-1)-1 SHALL clamp to that value and results below -2^(OUT_W-1) SHALL clamp to that value, setting saturated=1; otherwise saturated=0 and the value is passed exactly.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 start in the FINISH-to-IDLE transition cycle SHALL NOT be accepted; it is sampled only in IDLE.

Reset
REQ-025 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, input_current=0, saturated=0, clear the accumulator, and abort any accumulation with no done pulse.
REQ-026 reset_n SHALL take priority over start.

Configuration
REQ-027 With SCA_BIAS_EN defined, the module SHALL add a port bias (input, W, signed) that is registered at start and preloaded into the accumulator before block 0.
REQ-028 Without SCA_BIAS_EN, the bias port SHALL be absent and the accumulator SHALL start at 0; latency SHALL be identical in both builds.

Structure
REQ-029 Package sca_pkg SHALL hold the FSM state typedef and the clog2-based width and block-count constant functions.
REQ-030 The combinational per-block masked signed sum SHALL be a sub-module sca_lane_sum parametrised by LANES and W.

Verification (defaults unless stated)
REQ-031 All 24 spikes, all weights +10 -> sum 240 -> input_current=127, saturated=1, done 7 cycles after start.
REQ-032 Spikes on bits 0,1,2 only, weights 5, -3, 7 (others 100) -> input_current=9, saturated=0.
REQ-033 All spikes, all weights -128 -> sum -3072 -> input_current=-128, saturated=1.
REQ-034 Spikes=0 -> input_current=0, done 7 cycles after start; start pulses at cycles 2-5 are ignored, giving a single done.
REQ-035 reset_n=0 during the third ACCUM cycle -> no done, all outputs 0, busy=0; a fresh start then completes normally.
REQ-036 M=10, LANES=4, all spikes, weights 1..10 -> NB=3, padded lanes contribute 0, input_current=55, done 4 cycles after start; with SCA_BIAS_EN and bias=-60 -> -5.
